arcade_input_mapper: RTL and testbench

//  Parametrised player-input front end for arcade cores: decodes hps_io ps2_key events and joystick words

---
 rtl/arcade_input_pkg.sv | 112 +++++++++++
 rtl/coin_pulser.sv | 79 +++++++
 rtl/arcade_input_mapper.sv | 247 ++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input front end.
//   rot_mode_e   : screen rotation select
//   coin_state_e : coin pulser states
//   key_evt_t    : one decoded ps2_key event
//   JOY_*        : bit positions inside a 16-bit joystick word
//   KEY_*        : {extended, scancode} values of mapped keys
//   KL_*         : bit positions inside the key-state vector
package arcade_input_pkg;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_CCW  = 2'd2,
    ROT_180  = 2'd3
  } rot_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } coin_state_e;

  // One decoded keyboard event; code is {extended, scancode}
  typedef struct packed {
    logic       valid;
    logic       pressed;
    logic [8:0] code;
  } key_evt_t;

  // Joystick word layout (start/coin follow the buttons)
  localparam int unsigned JOY_WORD_W = 16;
  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_BTN0   = 4;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Player 0: arrows (extended) and keypad 8/2/4/6 (non-extended)
  localparam logic [8:0] KEY_UP_E    = 9'h175;
  localparam logic [8:0] KEY_DOWN_E  = 9'h172;
  localparam logic [8:0] KEY_LEFT_E  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT_E = 9'h174;
  localparam logic [8:0] KEY_KP8     = 9'h075;
  localparam logic [8:0] KEY_KP2     = 9'h072;
  localparam logic [8:0] KEY_KP4     = 9'h06B;
  localparam logic [8:0] KEY_KP6     = 9'h074;
  localparam logic [8:0] KEY_LCTRL   = 9'h014;
  localparam logic [8:0] KEY_LALT    = 9'h011;
  localparam logic [8:0] KEY_SPACE   = 9'h029;
  localparam logic [8:0] KEY_LSHIFT  = 9'h012;
  // Player 1
  localparam logic [8:0] KEY_R       = 9'h02D;
  localparam logic [8:0] KEY_F       = 9'h02B;
  localparam logic [8:0] KEY_D       = 9'h023;
  localparam logic [8:0] KEY_G       = 9'h034;
  localparam logic [8:0] KEY_A       = 9'h01C;
  localparam logic [8:0] KEY_S       = 9'h01B;
  localparam logic [8:0] KEY_Q       = 9'h015;
  localparam logic [8:0] KEY_W       = 9'h01D;
  // Start / coin
  localparam logic [8:0] KEY_F1      = 9'h005;
  localparam logic [8:0] KEY_F2      = 9'h006;
  localparam logic [8:0] KEY_1       = 9'h016;
  localparam logic [8:0] KEY_2       = 9'h01E;
  localparam logic [8:0] KEY_5       = 9'h02E;
  localparam logic [8:0] KEY_6       = 9'h036;

  // Key-state vector layout: two 8-line player blocks, then starts, then coins
  localparam int unsigned KL_UP      = 0;
  localparam int unsigned KL_DOWN    = 1;
  localparam int unsigned KL_LEFT    = 2;
  localparam int unsigned KL_RIGHT   = 3;
  localparam int unsigned KL_BTN0    = 4;
  localparam int unsigned KL_STRIDE  = 8;
  localparam int unsigned KL_START0  = 16;
  localparam int unsigned KL_COIN0   = 18;
  localparam int unsigned KEY_LINES  = 20;

  // Which key-state lines a {ext, code} value drives; zero for unmapped keys
  function automatic logic [KEY_LINES-1:0] key_line_mask(input logic [8:0] key);
    logic [KEY_LINES-1:0] m;
    m = '0;
    case (key)
      KEY_UP_E,    KEY_KP8: m[KL_UP]                  = 1'b1;
      KEY_DOWN_E,  KEY_KP2: m[KL_DOWN]                = 1'b1;
      KEY_LEFT_E,  KEY_KP4: m[KL_LEFT]                = 1'b1;
      KEY_RIGHT_E, KEY_KP6: m[KL_RIGHT]               = 1'b1;
      KEY_LCTRL:            m[KL_BTN0]                = 1'b1;
      KEY_LALT:             m[KL_BTN0+1]              = 1'b1;
      KEY_SPACE:            m[KL_BTN0+2]              = 1'b1;
      KEY_LSHIFT:           m[KL_BTN0+3]              = 1'b1;
      KEY_R:                m[KL_STRIDE+KL_UP]        = 1'b1;
      KEY_F:                m[KL_STRIDE+KL_DOWN]      = 1'b1;
      KEY_D:                m[KL_STRIDE+KL_LEFT]      = 1'b1;
      KEY_G:                m[KL_STRIDE+KL_RIGHT]     = 1'b1;
      KEY_A:                m[KL_STRIDE+KL_BTN0]      = 1'b1;
      KEY_S:                m[KL_STRIDE+KL_BTN0+1]    = 1'b1;
      KEY_Q:                m[KL_STRIDE+KL_BTN0+2]    = 1'b1;
      KEY_W:                m[KL_STRIDE+KL_BTN0+3]    = 1'b1;
      KEY_F1, KEY_1:        m[KL_START0]              = 1'b1;
      KEY_F2, KEY_2:        m[KL_START0+1]            = 1'b1;
      KEY_5:                m[KL_COIN0]               = 1'b1;
      KEY_6:                m[KL_COIN0+1]             = 1'b1;
      default:              m                         = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Timed coin pulse for one player.
// A rising edge of req starts PULSE_CYCLES of coin high, followed by
// PULSE_CYCLES of holdoff; edges seen outside IDLE are dropped.
//   clk_sys : system clock
//   rst_n   : asynchronous reset, active low
//   req     : coin request level
//   coin    : registered coin pulse
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2400000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic req,
  output logic coin
);

  localparam int unsigned        CNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  coin_state_e      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             req_q;
  logic             req_rise;

  // req_q resets high so a request held across reset needs a fresh edge
  assign req_rise = req & ~req_q;

  // State, counter, edge detector and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b1;
      coin    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      req_q   <= req;
      coin    <= (state_n == PULSE);
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_n = PULSE;
          cnt_n   = '0;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_LAST) begin
          state_n = HOLDOFF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: decodes hps_io ps2_key events and joystick words
// into per-player direction/button/start/coin lines with rotation remap and
// timed coin pulses. Optional autofire is built when AUTOFIRE_EN is defined.
//   clk_sys, RESET_N        : clock, asynchronous active-low reset
//   ps2_key[64:0]           : key event, bit 64 toggles per event
//   joystick[16*NP-1:0]     : player p word at [16p+15:16p]
//   rot_mode[1:0]           : rot_mode_e
//   joy_merge               : OR all joystick words into player 0
//   coin_on_start           : start also requests a coin
//   autofire[NP*NB-1:0]     : per-button autofire enable (AUTOFIRE_EN only)
//   p_up/p_down/p_left/p_right[NP-1:0] : rotated directions
//   p_btn[NP*NB-1:0]        : button b of player p at [p*NB+b]
//   p_start[NP-1:0]         : start level
//   p_coin[NP-1:0]          : coin pulse
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned NUM_BUTTONS       = 4,
  parameter int unsigned COIN_PULSE_CYCLES = 2400000
`ifdef AUTOFIRE_EN
  , parameter int unsigned AUTOFIRE_HALF_PERIOD = 1200000
`endif
) (
  input  logic                             clk_sys,
  input  logic                             RESET_N,
  input  logic [64:0]                      ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]        joystick,
  input  logic [1:0]                       rot_mode,
  input  logic                             joy_merge,
  input  logic                             coin_on_start,
`ifdef AUTOFIRE_EN
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire,
`endif
  output logic [NUM_PLAYERS-1:0]           p_up,
  output logic [NUM_PLAYERS-1:0]           p_down,
  output logic [NUM_PLAYERS-1:0]           p_left,
  output logic [NUM_PLAYERS-1:0]           p_right,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] p_btn,
  output logic [NUM_PLAYERS-1:0]           p_start,
  output logic [NUM_PLAYERS-1:0]           p_coin
);

  localparam int unsigned NPB = NUM_PLAYERS * NUM_BUTTONS;

  // ---------------------------------------------------------------- keys
  logic                 key_sample_q;
  logic                 primed_q;
  logic [KEY_LINES-1:0] key_state_q;
  key_evt_t             key_evt_c;
  logic [KEY_LINES-1:0] key_mask_c;

  // Decode the current ps2_key word; valid only on a toggle once primed
  always_comb begin
    key_evt_c         = '0;
    key_evt_c.pressed = (ps2_key[15:8] != PS2_BREAK);
    key_evt_c.code    = {(key_evt_c.pressed ? (ps2_key[15:8] == PS2_EXT)
                                            : (ps2_key[23:16] == PS2_EXT)),
                         ps2_key[7:0]};
    key_evt_c.valid   = primed_q && (ps2_key[64] != key_sample_q)
                        && (ps2_key[63:24] == 40'h0);
  end

  assign key_mask_c = key_line_mask(key_evt_c.code);

  // First clock after reset only captures the toggle bit
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      key_sample_q <= 1'b0;
      primed_q     <= 1'b0;
      key_state_q  <= '0;
    end else begin
      key_sample_q <= ps2_key[64];
      primed_q     <= 1'b1;
      if (key_evt_c.valid) begin
        key_state_q <= key_evt_c.pressed ? (key_state_q | key_mask_c)
                                         : (key_state_q & ~key_mask_c);
      end
    end
  end

  // ------------------------------------------------------- raw per player
  logic [JOY_WORD_W-1:0]  joy_others_c;
  logic [NUM_PLAYERS-1:0] raw_up, raw_down, raw_left, raw_right;
  logic [NUM_PLAYERS-1:0] raw_start, raw_coin, coin_req;
  logic [NPB-1:0]         raw_btn;
  logic                   unused_key_lines;

  assign unused_key_lines = ^key_state_q;

  // OR of players 1..N-1, folded into player 0 when merging
  always_comb begin
    joy_others_c = '0;
    for (int unsigned p = 1; p < NUM_PLAYERS; p++) begin
      joy_others_c = joy_others_c | joystick[16*p +: 16];
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [JOY_WORD_W-1:0]  joy_w;
    logic                   k_up, k_down, k_left, k_right, k_start, k_coin;
    logic [NUM_BUTTONS-1:0] k_btn;
    logic                   unused_joy_bits;

    // Merged players lose their own word; it already feeds player 0
    if (p == 0) begin : g_p0
      assign joy_w = joystick[15:0] | (joy_merge ? joy_others_c : '0);
    end else begin : g_pn
      assign joy_w = joy_merge ? '0 : joystick[16*p +: 16];
    end

    assign unused_joy_bits = ^joy_w;

    // Keyboard covers players 0 and 1 only
    if (p < 2) begin : g_key
      localparam int unsigned KB = p * KL_STRIDE;
      assign k_up    = key_state_q[KB + KL_UP];
      assign k_down  = key_state_q[KB + KL_DOWN];
      assign k_left  = key_state_q[KB + KL_LEFT];
      assign k_right = key_state_q[KB + KL_RIGHT];
      assign k_btn   = key_state_q[KB + KL_BTN0 +: NUM_BUTTONS];
      assign k_start = key_state_q[KL_START0 + p];
      assign k_coin  = key_state_q[KL_COIN0 + p];
    end else begin : g_nokey
      assign k_up    = 1'b0;
      assign k_down  = 1'b0;
      assign k_left  = 1'b0;
      assign k_right = 1'b0;
      assign k_btn   = '0;
      assign k_start = 1'b0;
      assign k_coin  = 1'b0;
    end

    assign raw_up[p]    = k_up    | joy_w[JOY_UP];
    assign raw_down[p]  = k_down  | joy_w[JOY_DOWN];
    assign raw_left[p]  = k_left  | joy_w[JOY_LEFT];
    assign raw_right[p] = k_right | joy_w[JOY_RIGHT];
    assign raw_btn[p*NUM_BUTTONS +: NUM_BUTTONS] = k_btn | joy_w[JOY_BTN0 +: NUM_BUTTONS];
    assign raw_start[p] = k_start | joy_w[JOY_BTN0 + NUM_BUTTONS];
    assign raw_coin[p]  = k_coin  | joy_w[JOY_BTN0 + NUM_BUTTONS + 1];
    assign coin_req[p]  = raw_coin[p] | (coin_on_start & raw_start[p]);

    coin_pulser #(
      .PULSE_CYCLES (COIN_PULSE_CYCLES)
    ) u_coin (
      .clk_sys (clk_sys),
      .rst_n   (RESET_N),
      .req     (coin_req[p]),
      .coin    (p_coin[p])
    );
  end

  // ------------------------------------------------------------ rotation
  logic [NUM_PLAYERS-1:0] rot_up_c, rot_down_c, rot_left_c, rot_right_c;

  always_comb begin
    rot_up_c    = raw_up;
    rot_down_c  = raw_down;
    rot_left_c  = raw_left;
    rot_right_c = raw_right;
    case (rot_mode_e'(rot_mode))
      ROT_CW: begin
        rot_up_c    = raw_left;
        rot_down_c  = raw_right;
        rot_left_c  = raw_down;
        rot_right_c = raw_up;
      end
      ROT_CCW: begin
        rot_up_c    = raw_right;
        rot_down_c  = raw_left;
        rot_left_c  = raw_up;
        rot_right_c = raw_down;
      end
      ROT_180: begin
        rot_up_c    = raw_down;
        rot_down_c  = raw_up;
        rot_left_c  = raw_right;
        rot_right_c = raw_left;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ buttons
  logic [NPB-1:0] btn_out_c;

`ifdef AUTOFIRE_EN
  localparam int unsigned AF_W = $clog2(AUTOFIRE_HALF_PERIOD + 1);

  logic [AF_W-1:0] af_cnt_q, af_cnt_n;
  logic            af_phase_q, af_phase_n;
  logic [NPB-1:0]  af_btn_q;
  logic [NPB-1:0]  af_press_c;

  assign af_press_c = raw_btn & ~af_btn_q & autofire;

  // Shared phase; any enabled press restarts it high
  always_comb begin
    af_cnt_n   = af_cnt_q + AF_W'(1);
    af_phase_n = af_phase_q;
    if (|af_press_c) begin
      af_cnt_n   = '0;
      af_phase_n = 1'b1;
    end else if (af_cnt_q == AF_W'(AUTOFIRE_HALF_PERIOD - 1)) begin
      af_cnt_n   = '0;
      af_phase_n = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
      af_btn_q   <= '0;
    end else begin
      af_cnt_q   <= af_cnt_n;
      af_phase_q <= af_phase_n;
      af_btn_q   <= raw_btn;
    end
  end

  // Next phase is used so the first registered output after a press is high
  assign btn_out_c = raw_btn & (~autofire | {NPB{af_phase_n}});
`else
  assign btn_out_c = raw_btn;
`endif

  // --------------------------------------------------------- output regs
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      p_up    <= '0;
      p_down  <= '0;
      p_left  <= '0;
      p_right <= '0;
      p_btn   <= '0;
      p_start <= '0;
    end else begin
      p_up    <= rot_up_c;
      p_down  <= rot_down_c;
      p_left  <= rot_left_c;
      p_right <= rot_right_c;
      p_btn   <= btn_out_c;
      p_start <= raw_start;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper (2 players, 4 buttons,
// 8-cycle coin pulse). Joystick/rotation vectors come from a table and are
// checked through a scoreboard queue; keyboard, coin, reset and autofire
// corner cases are hand-written sequences.
module tb_arcade_input_mapper;
  import arcade_input_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned NB = 4;
  localparam int unsigned CP = 8;

  logic              clk_sys = 1'b0;
  logic              RESET_N = 1'b0;
  logic [64:0]       ps2_key = '0;
  logic [31:0]       joystick = '0;
  logic [1:0]        rot_mode = 2'd0;
  logic              joy_merge = 1'b0;
  logic              coin_on_start = 1'b0;
`ifdef AUTOFIRE_EN
  logic [NP*NB-1:0]  autofire = '0;
`endif
  logic [NP-1:0]     p_up, p_down, p_left, p_right, p_start, p_coin;
  logic [NP*NB-1:0]  p_btn;

  arcade_input_mapper #(
    .NUM_PLAYERS       (NP),
    .NUM_BUTTONS       (NB),
    .COIN_PULSE_CYCLES (CP)
`ifdef AUTOFIRE_EN
    , .AUTOFIRE_HALF_PERIOD (4)
`endif
  ) dut (
    .clk_sys       (clk_sys),
    .RESET_N       (RESET_N),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .rot_mode      (rot_mode),
    .joy_merge     (joy_merge),
    .coin_on_start (coin_on_start),
`ifdef AUTOFIRE_EN
    .autofire      (autofire),
`endif
    .p_up          (p_up),
    .p_down        (p_down),
    .p_left        (p_left),
    .p_right       (p_right),
    .p_btn         (p_btn),
    .p_start       (p_start),
    .p_coin        (p_coin)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [31:0] joy;
    logic [1:0]  rot;
    logic        merge;
    logic [1:0]  up, down, left, right;
    logic [7:0]  btn;
    logic [1:0]  start;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  up, down, left, right, start, coin;
    logic [7:0]  btn;
  } exp_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  exp_t sb [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // New key event: flip the toggle bit and present the 24-bit code
  task automatic key_evt(input logic [23:0] code);
    ps2_key = {~ps2_key[64], 40'h0, code};
  endtask

  // Count cycles p_coin[p] is high over n clocks; first = 1-based tick of first high
  task automatic count_coin(input int p, input int n, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int t = 1; t <= n; t++) begin
      tick(1);
      if (p_coin[p]) begin
        cnt++;
        if (first == 0) first = t;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt, first;
    exp_t e;

    //            joy            rot       mg   up    down  left  right btn    start
    vecs[0]  = '{32'h0000_0000, ROT_NONE, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00};
    vecs[1]  = '{32'h0000_0001, ROT_NONE, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 8'h00, 2'b00};
    vecs[2]  = '{32'h0000_0002, ROT_CW,   1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00};
    vecs[3]  = '{32'h0000_0002, ROT_180,  1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 8'h00, 2'b00};
    vecs[4]  = '{32'h0000_0008, ROT_CW,   1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 8'h00, 2'b00};
    vecs[5]  = '{32'h0000_0008, ROT_CCW,  1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 8'h00, 2'b00};
    vecs[6]  = '{32'h0004_0000, ROT_CCW,  1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 8'h00, 2'b00};
    vecs[7]  = '{32'h0040_0000, ROT_NONE, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h40, 2'b00};
    vecs[8]  = '{32'h0010_0000, ROT_NONE, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h01, 2'b00};
    vecs[9]  = '{32'h0100_0100, ROT_NONE, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 2'b11};
    vecs[10] = '{32'h0000_0081, ROT_180,  1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 8'h08, 2'b00};
    vecs[11] = '{32'h0000_000A, ROT_CW,   1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 8'h00, 2'b00};
    vecs[12] = '{32'h0008_0000, ROT_NONE, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00};
    vecs[13] = '{32'h0008_0001, ROT_CCW,  1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 8'h00, 2'b00};

    // Reset held with toggle bit high and keypad-8 in the low byte
    ps2_key = {1'b1, 40'h0, 24'h000075};
    tick(2);
    check("reset_dirs",  {p_up, p_down, p_left, p_right}, 0);
    check("reset_btn",   p_btn, 0);
    check("reset_start_coin", {p_start, p_coin}, 0);

    RESET_N = 1'b1;
    tick(4);
    check("prime_no_decode", {p_up, p_down, p_left, p_right, p_btn, p_start, p_coin}, 0);

    // Extended up arrow: two-edge latency, then break
    key_evt(24'h00E075);
    tick(1);
    check("arrow_up_edge1", p_up, 2'b00);
    tick(1);
    check("arrow_up_edge2", p_up, 2'b01);
    key_evt(24'hE0F075);
    tick(2);
    check("arrow_up_break", p_up, 2'b00);

    key_evt(24'h000014);  tick(2); check("lctrl_make",  p_btn, 8'h01);
    key_evt(24'h00F014);  tick(2); check("lctrl_break", p_btn, 8'h00);
    key_evt(24'h00E014);  tick(2); check("rctrl_ignored", p_btn, 8'h00);
    key_evt(24'h00002D);  tick(2); check("p1_r_make",   p_up, 2'b10);
    key_evt(24'h00F02D);  tick(2); check("p1_r_break",  p_up, 2'b00);
    key_evt(24'h000005);  tick(2); check("f1_start",    p_start, 2'b01);
    key_evt(24'h00F005);  tick(2); check("f1_release",  p_start, 2'b00);
    ps2_key = {~ps2_key[64], 40'h1, 24'h000029};
    tick(2);
    check("high_bits_discard", p_btn, 8'h00);

    // Table: joystick/rotation/merge, one-edge latency via scoreboard
    for (int i = 0; i < NV; i++) begin
      joystick  = vecs[i].joy;
      rot_mode  = vecs[i].rot;
      joy_merge = vecs[i].merge;
      sb.push_back('{i, vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right,
                     vecs[i].start, 2'b00, vecs[i].btn});
      tick(1);
      e = sb.pop_front();
      check($sformatf("vec%0d_up", e.idx),    p_up,    e.up);
      check($sformatf("vec%0d_down", e.idx),  p_down,  e.down);
      check($sformatf("vec%0d_left", e.idx),  p_left,  e.left);
      check($sformatf("vec%0d_right", e.idx), p_right, e.right);
      check($sformatf("vec%0d_btn", e.idx),   p_btn,   e.btn);
      check($sformatf("vec%0d_start", e.idx), p_start, e.start);
      check($sformatf("vec%0d_coin", e.idx),  p_coin,  e.coin);
    end
    check("scoreboard_empty", sb.size(), 0);
    joystick = '0; rot_mode = ROT_NONE; joy_merge = 1'b0;
    tick(2);

    // Coin key held 40 cycles: one 8-cycle pulse starting on edge 2
    key_evt(24'h00002E);
    count_coin(0, 40, cnt, first);
    check("coin0_high_cycles", cnt, CP);
    check("coin0_first_tick", first, 2);
    check("coin0_low_after", p_coin, 2'b00);
    key_evt(24'h00F02E);
    tick(3);
    key_evt(24'h00002E);
    count_coin(0, 20, cnt, first);
    check("coin0_repress", cnt, CP);
    key_evt(24'h00F02E);
    tick(2);

    // Player 1 coin: release and re-press inside holdoff gives no second pulse
    key_evt(24'h000036);
    cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(1);
      if (p_coin[1]) cnt++;
      if (t == 10) key_evt(24'h00F036);
      if (t == 13) key_evt(24'h000036);
    end
    check("coin1_holdoff_ignored", cnt, CP);
    check("coin1_p0_quiet", p_coin[0], 1'b0);
    key_evt(24'h00F036);
    tick(2);

    // Start requests coin when coin_on_start is set
    coin_on_start = 1'b1;
    joystick      = 32'h0000_0100;
    count_coin(0, 30, cnt, first);
    check("coin_on_start_pulse", cnt, CP);
    check("coin_on_start_level", p_start, 2'b01);
    joystick      = '0;
    coin_on_start = 1'b0;
    tick(20);

    // Reset mid-pulse with the joystick coin held: no retrigger until a new edge
    joystick = 32'h0000_0200;
    tick(3);
    check("coin_mid_pulse", p_coin, 2'b01);
    #2 RESET_N = 1'b0;
    #1;
    check("coin_async_drop", p_coin, 2'b00);
    tick(1);
    RESET_N = 1'b1;
    count_coin(0, 30, cnt, first);
    check("coin_held_after_reset", cnt, 0);
    joystick = '0;
    tick(1);
    joystick = 32'h0000_0200;
    count_coin(0, 20, cnt, first);
    check("coin_new_edge", cnt, CP);
    joystick = '0;
    tick(2);

`ifdef AUTOFIRE_EN
    // btn0 autofire 4 high / 4 low; btn1 held without autofire stays high
    autofire = 8'h01;
    joystick = 32'h0000_0030;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check($sformatf("af_btn0_t%0d", i), p_btn[0], ((i / 4) % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("af_btn1_t%0d", i), p_btn[1], 1'b1);
    end
    joystick = '0;
    tick(1);
    check("af_release", p_btn, 8'h00);
    autofire = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
